// File: rtl/popcount_pkg.sv
// Shared types and width helpers for the popcount arbiter.
// Optional accumulators are enabled by defining POPCNT_ACCUM_EN.
package popcount_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        RESP
    } state_t;

    function automatic int cnt_w(input int n);
        return $clog2(n) + 1;
    endfunction

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/popcount_arbiter_if.sv
// Request/response bundle between the word producers and the arbiter.
// POPCNT_ACCUM_EN adds acc_clr and resp_total.
interface popcount_arbiter_if
    import popcount_pkg::*;
#(
    parameter int inCount = 32,
    parameter int NREQ    = 4
`ifdef POPCNT_ACCUM_EN
    ,
    parameter int ACC_W   = 16
`endif
);
    localparam int CW = cnt_w(inCount);
    localparam int IW = id_w(NREQ);

    logic [NREQ-1:0]         req_valid;
    logic [NREQ*inCount-1:0] req_data;
    logic [NREQ-1:0]         req_ready;
    logic                    resp_valid;
    logic                    resp_ready;
    logic [IW-1:0]           resp_id;
    logic [CW-1:0]           resp_count;
`ifdef POPCNT_ACCUM_EN
    logic                    acc_clr;
    logic [ACC_W-1:0]        resp_total;
`endif

    modport master (
        output req_valid, req_data, resp_ready,
`ifdef POPCNT_ACCUM_EN
        output acc_clr,
        input  resp_total,
`endif
        input  req_ready, resp_valid, resp_id, resp_count
    );

    modport slave (
        input  req_valid, req_data, resp_ready,
`ifdef POPCNT_ACCUM_EN
        input  acc_clr,
        output resp_total,
`endif
        output req_ready, resp_valid, resp_id, resp_count
    );

endinterface

// File: rtl/popcount_arbiter_ones_count.sv
// Combinational population count of one operand word.
// Unaffected by POPCNT_ACCUM_EN.
module ones_count #(
    parameter int inCount = 32
) (
    input  logic [inCount-1:0]   i_data,
    output logic [$clog2(inCount):0] o_count
);
    localparam int CW = $clog2(inCount) + 1;

    // Sum every bit of the operand.
    always_comb begin
        o_count = '0;
        for (int i = 0; i < inCount; i++) begin
            o_count = o_count + CW'(i_data[i]);
        end
    end

endmodule

// File: rtl/popcount_arbiter.sv
// Round-robin arbiter sharing one ones_count among NREQ requesters.
// Define POPCNT_ACCUM_EN for per-requester running totals.
module popcount_arbiter
    import popcount_pkg::*;
#(
    parameter int inCount = 32,
    parameter int NREQ    = 4
`ifdef POPCNT_ACCUM_EN
    ,
    parameter int ACC_W   = 16
`endif
) (
    input  logic              clk,
    input  logic              rst,
    popcount_arbiter_if.slave bus
);
    localparam int CW = cnt_w(inCount);
    localparam int IW = id_w(NREQ);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [IW-1:0]       r_rr_ptr;
    logic [IW-1:0]       r_id;
    logic [IW-1:0]       r_resp_id;
    logic [inCount-1:0]  r_operand;
    logic [CW-1:0]       r_resp_count;
    logic                r_resp_valid;
    logic [CW-1:0]       w_count;
    logic                w_found;
    logic [IW-1:0]       w_grant;
    logic [IW-1:0]       w_ptr_nxt;
    logic [NREQ-1:0]     w_req_ready;

    // First valid requester at or after the pointer; the
    // descending loop lets the smallest offset win.
    function automatic logic [IW:0] rr_pick(
        input logic [NREQ-1:0] v,
        input logic [IW-1:0]   p
    );
        int idx;
        rr_pick = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(p) + k) % NREQ;
            if (v[idx]) begin
                rr_pick = {1'b1, IW'(idx)};
            end
        end
    endfunction

    assign {w_found, w_grant} = rr_pick(bus.req_valid, r_rr_ptr);

    assign w_ptr_nxt = (int'(w_grant) == NREQ - 1) ? '0
                                                   : w_grant + IW'(1);

    ones_count #(
        .inCount(inCount)
    ) u_ones_count (
        .i_data (r_operand),
        .o_count(w_count)
    );

    // Next state and the combinational request grant.
    always_comb begin
        w_state_nxt = r_state;
        w_req_ready = '0;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nxt = COUNT;
                    if (!rst) begin
                        w_req_ready[w_grant] = 1'b1;
                    end
                end
            end
            COUNT: w_state_nxt = RESP;
            RESP: begin
                if (bus.resp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register, operand capture and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_rr_ptr     <= '0;
            r_id         <= '0;
            r_operand    <= '0;
            r_resp_id    <= '0;
            r_resp_count <= '0;
            r_resp_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_operand <= bus.req_data[w_grant*inCount +: inCount];
                        r_id      <= w_grant;
                        r_rr_ptr  <= w_ptr_nxt;
                    end
                end
                COUNT: begin
                    r_resp_count <= w_count;
                    r_resp_id    <= r_id;
                    r_resp_valid <= 1'b1;
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        r_resp_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready  = w_req_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_id    = r_resp_id;
    assign bus.resp_count = r_resp_count;

`ifdef POPCNT_ACCUM_EN
    logic [ACC_W-1:0] r_acc [NREQ];
    logic [ACC_W-1:0] w_total;

    assign w_total = r_acc[r_resp_id] + ACC_W'(r_resp_count);

    // Running totals; clear wins over a same-cycle add.
    always_ff @(posedge clk) begin
        if (rst || bus.acc_clr) begin
            for (int i = 0; i < NREQ; i++) begin
                r_acc[i] <= '0;
            end
        end else if (r_resp_valid && bus.resp_ready) begin
            r_acc[r_resp_id] <= w_total;
        end
    end

    assign bus.resp_total = w_total;
`endif

endmodule
